// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg
// Shared constants, types and small helpers for the 8-digit 7-segment scan controller.
//   NUM_DIGITS - number of multiplexed digit positions
//   IDX_W      - width of the slot index
//   AN_ALL_OFF - anode pattern with every digit dark (anodes are active-low)
package seg7_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 8'hFF;

  typedef logic [IDX_W-1:0] idx_t;

  // Hex nibble shown in slot idx.
  function automatic logic [3:0] nibble_sel(input logic [31:0] val, input idx_t idx);
    return val[{idx, 2'b00} +: 4];
  endfunction

  // One-hot-low anode select for slot idx.
  function automatic logic [NUM_DIGITS-1:0] an_sel(input idx_t idx);
    return ~(8'b1 << idx);
  endfunction

  // A slot is a leading zero when it and every more significant nibble are zero.
  // Slot 0 is never treated as leading so that a value of 0 still shows "0".
  function automatic logic lz_blanked(input logic [31:0] val, input idx_t idx);
    return (idx != '0) && ((val >> {idx, 2'b00}) == 32'd0);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
// CPU-side control and display-side outputs of the scan controller.
//   enable     - 1 = scan running, 0 = all anodes off
//   load       - 1-cycle strobe capturing data_in
//   data_in    - 32-bit value, nibble i shown at position i (0 = rightmost)
//   blank_lz   - suppress leading zero digits
//   digit      - hex nibble of the current slot (to the segment decoder)
//   an         - active-low anode selects
//   pending    - a captured value waits for the frame boundary
//   frame_done - 1-cycle pulse after the slot index wraps 7->0
// master: drives the controls (CPU / bench); slave: the scan controller.
interface seg7_scan_ctrl_if;
  import seg7_scan_ctrl_pkg::*;

  logic                  enable;
  logic                  load;
  logic [31:0]           data_in;
  logic                  blank_lz;
  logic [3:0]            digit;
  logic [NUM_DIGITS-1:0] an;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output enable, load, data_in, blank_lz,
    input  digit, an, pending, frame_done
  );

  modport slave (
    input  enable, load, data_in, blank_lz,
    output digit, an, pending, frame_done
  );

endinterface

// File: rtl/seg7_scan_ctrl_tick.sv
// scan_tick_gen
// Prescaler producing one tick every SCAN_DIV clocks while enabled.
//   i_clk    - system clock
//   i_rst_n  - asynchronous active-low reset
//   i_enable - count when 1; synchronously cleared to 0 when 0
//   o_tick   - high in the cycle where the count equals SCAN_DIV-1
// SCAN_DIV must be at least 2 and fit in CNT_W bits.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;
  logic             w_last;

  always_comb begin
    w_last = (r_count == LastCnt);
    if (!i_enable || w_last) begin
      w_count_d = '0;
    end else begin
      w_count_d = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_tick = i_enable && w_last;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Captured values are held back until the frame wraps so a frame never mixes digits
// from two different values.
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset
//   bus     - seg7_scan_ctrl_if.slave: enable/load/data_in/blank_lz in,
//             digit/an/pending/frame_done out (all outputs registered)
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  logic                  w_tick;
  logic                  w_wrap;

  idx_t                  r_idx;
  idx_t                  w_idx_d;
  logic [31:0]           r_disp;
  logic [31:0]           w_disp_d;
  logic [31:0]           r_pend;
  logic [31:0]           w_pend_d;
  logic                  r_pending;
  logic                  w_pending_d;
  logic [3:0]            r_digit;
  logic [3:0]            w_digit_d;
  logic [NUM_DIGITS-1:0] r_an;
  logic [NUM_DIGITS-1:0] w_an_d;
  logic                  r_frame_done;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (bus.enable),
    .o_tick   (w_tick)
  );

  assign w_wrap = w_tick && (r_idx == idx_t'(NUM_DIGITS - 1));

  // Slot index: held at 0 while disabled so scanning restarts from slot 0.
  always_comb begin
    if (!bus.enable) begin
      w_idx_d = '0;
    end else if (w_tick) begin
      w_idx_d = r_idx + idx_t'(1);
    end else begin
      w_idx_d = r_idx;
    end
  end

  // Load handshake. A load in the wrap cycle bypasses the pending buffer; while
  // disabled there is no frame to tear, so a pending value moves over at once.
  always_comb begin
    w_disp_d    = r_disp;
    w_pend_d    = r_pend;
    w_pending_d = r_pending;
    if (bus.load && w_wrap) begin
      w_disp_d    = bus.data_in;
      w_pending_d = 1'b0;
    end else if (bus.load) begin
      w_pend_d    = bus.data_in;
      w_pending_d = 1'b1;
    end else if (r_pending && (w_wrap || !bus.enable)) begin
      w_disp_d    = r_pend;
      w_pending_d = 1'b0;
    end
  end

  // Outputs are computed from next-state idx/disp so they change together with
  // the slot and a freshly transferred value shows from slot 0 of its frame.
  always_comb begin
    w_digit_d = nibble_sel(w_disp_d, w_idx_d);
    if (!bus.enable) begin
      w_an_d = AN_ALL_OFF;
    end else if (bus.blank_lz && lz_blanked(w_disp_d, w_idx_d)) begin
      w_an_d = AN_ALL_OFF;
    end else begin
      w_an_d = an_sel(w_idx_d);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pending    <= 1'b0;
      r_digit      <= '0;
      r_an         <= AN_ALL_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_idx        <= w_idx_d;
      r_disp       <= w_disp_d;
      r_pend       <= w_pend_d;
      r_pending    <= w_pending_d;
      r_digit      <= w_digit_d;
      r_an         <= w_an_d;
      r_frame_done <= w_wrap;
    end
  end

  assign bus.digit      = r_digit;
  assign bus.an         = r_an;
  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Directed self-checking bench for seg7_scan_ctrl with SCAN_DIV=4 (32-cycle frames).
module tb_seg7_scan_ctrl;

  localparam logic [63:0] AnStd = 64'h7FBF_DFEF_F7FB_FDFE;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  seg7_scan_ctrl_if bus_if ();

  seg7_scan_ctrl #(
    .SCAN_DIV (4),
    .CNT_W    (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until frame_done, checking held values on the way; bounded.
  task automatic run_to_frame(input bit chk_dig, input logic [3:0] exp_dig,
                              input logic exp_pend);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (bus_if.frame_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (chk_dig) chk("hold_digit", bus_if.digit, exp_dig);
        chk("hold_pending", bus_if.pending, exp_pend);
      end
    end
    chk("frame_reached", seen, 1);
  endtask

  // Called at the first cycle of a frame; checks all 32 cycles and ends on the next frame start.
  task automatic check_frame(input logic [31:0] val, input logic [63:0] an_exp);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk("frame_done", bus_if.frame_done, (s == 0 && c == 0));
        chk("digit", bus_if.digit, val[s*4 +: 4]);
        chk("an", bus_if.an, an_exp[s*8 +: 8]);
        chk("pending", bus_if.pending, 0);
        step();
      end
    end
    chk("frame_period", bus_if.frame_done, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus_if.enable   = 1'b0;
    bus_if.load     = 1'b0;
    bus_if.data_in  = '0;
    bus_if.blank_lz = 1'b0;

    // Reset values
    #23;
    chk("rst_an", bus_if.an, 8'hFF);
    chk("rst_digit", bus_if.digit, 4'h0);
    chk("rst_pending", bus_if.pending, 0);
    chk("rst_frame_done", bus_if.frame_done, 0);
    rst_n = 1'b1;
    step();

    // 1: basic scan of 89ABCDEF
    bus_if.enable  = 1'b1;
    bus_if.load    = 1'b1;
    bus_if.data_in = 32'h89AB_CDEF;
    step();
    bus_if.load = 1'b0;
    chk("t1_pending", bus_if.pending, 1);
    run_to_frame(1'b0, 4'h0, 1'b1);
    check_frame(32'h89AB_CDEF, AnStd);

    // 2: mid-frame load must not tear the frame showing 22222222
    bus_if.load    = 1'b1;
    bus_if.data_in = 32'h2222_2222;
    step();
    bus_if.load = 1'b0;
    run_to_frame(1'b0, 4'h0, 1'b1);
    repeat (12) step();
    chk("t2_slot3_an", bus_if.an, 8'hF7);
    bus_if.load    = 1'b1;
    bus_if.data_in = 32'h1111_1111;
    step();
    bus_if.load = 1'b0;
    chk("t2_pending", bus_if.pending, 1);
    run_to_frame(1'b1, 4'h2, 1'b1);
    chk("t2_new_digit", bus_if.digit, 4'h1);
    chk("t2_pending_drop", bus_if.pending, 0);
    check_frame(32'h1111_1111, AnStd);

    // 3: load in the wrap cycle goes straight to the display
    repeat (31) step();
    bus_if.load    = 1'b1;
    bus_if.data_in = 32'h0000_ABCD;
    step();
    bus_if.load = 1'b0;
    chk("t3_frame_done", bus_if.frame_done, 1);
    chk("t3_pending", bus_if.pending, 0);
    check_frame(32'h0000_ABCD, AnStd);

    // 4: leading-zero blanking
    bus_if.blank_lz = 1'b1;
    bus_if.load     = 1'b1;
    bus_if.data_in  = 32'h0000_0305;
    step();
    bus_if.load = 1'b0;
    run_to_frame(1'b0, 4'h0, 1'b1);
    check_frame(32'h0000_0305, 64'hFFFF_FFFF_FFFB_FDFE);
    bus_if.load    = 1'b1;
    bus_if.data_in = 32'h0;
    step();
    bus_if.load = 1'b0;
    run_to_frame(1'b0, 4'h0, 1'b1);
    check_frame(32'h0, 64'hFFFF_FFFF_FFFF_FFFE);
    bus_if.blank_lz = 1'b0;

    // 5: back-to-back loads, last one wins
    bus_if.load    = 1'b1;
    bus_if.data_in = 32'h1;
    step();
    bus_if.data_in = 32'h2;
    step();
    bus_if.load = 1'b0;
    chk("t5_pending", bus_if.pending, 1);
    run_to_frame(1'b0, 4'h0, 1'b1);
    chk("t5_digit", bus_if.digit, 4'h2);
    check_frame(32'h2, AnStd);

    // 6: asynchronous reset at slot 5 with a pending value
    repeat (20) step();
    bus_if.load    = 1'b1;
    bus_if.data_in = 32'hDEAD_BEEF;
    step();
    bus_if.load = 1'b0;
    chk("t6_pending", bus_if.pending, 1);
    chk("t6_slot5_an", bus_if.an, 8'hDF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_an", bus_if.an, 8'hFF);
    chk("t6_rst_pending", bus_if.pending, 0);
    chk("t6_rst_digit", bus_if.digit, 4'h0);
    chk("t6_rst_frame_done", bus_if.frame_done, 0);
    #1 rst_n = 1'b1;
    run_to_frame(1'b1, 4'h0, 1'b0);
    check_frame(32'h0, AnStd);

    // enable=0: loads transfer immediately, anodes stay off, no frame pulses
    bus_if.enable = 1'b0;
    step();
    chk("dis_an", bus_if.an, 8'hFF);
    bus_if.load    = 1'b1;
    bus_if.data_in = 32'h7;
    step();
    bus_if.load = 1'b0;
    chk("dis_pending", bus_if.pending, 1);
    step();
    chk("dis_digit", bus_if.digit, 4'h7);
    chk("dis_pending_clr", bus_if.pending, 0);
    for (int n = 0; n < 10; n++) begin
      chk("dis_an_off", bus_if.an, 8'hFF);
      chk("dis_no_frame", bus_if.frame_done, 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
